rtc_burst_writer: RTL and testbench

Parametrised successor to the single-register RTC write controller: holds a table of N_REGS data bytes loaded by the user-interface logic and, on one start pulse, writes every masked entry to consecutive RTC registers over the multiplexed address/data bus. Sits between the button/edit FSMs and the shared RTC bus arbiter. Phase timing is set by parameter, not hard-coded, so the same block serves any clock rate.

---
 rtl/rtc_burst_writer.sv | 183 ++++++++++++++++++
 tb/tb_rtc_burst_writer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_burst_writer.sv
// Burst writer for the RTC register file: replays a loaded table of bytes onto the
// multiplexed address/data bus, one address phase and one data phase per masked entry.
module rtc_burst_writer #(
  parameter int                DATA_W    = 8,
  parameter int                N_REGS    = 8,
  parameter logic [DATA_W-1:0] ADDR_BASE = 8'h21,
  parameter int                PHASE_CYC = 4,
  localparam int               IDX_W     = (N_REGS > 1) ? $clog2(N_REGS) : 1,
  localparam int               CNT_W     = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [N_REGS-1:0] wr_mask,
  input  logic              start,
  output logic              AD,
  output logic              CS,
  output logic              WR,
  output logic              RD,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_oe,
  output logic [IDX_W-1:0]  cur_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    IDLE, SCAN,
    ADDR_SU, ADDR_ST, ADDR_HD, ADDR_GAP,
    DATA_SU, DATA_ST, DATA_HD, DATA_GAP,
    FIN
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [N_REGS-1:0] mask;
  logic [DATA_W-1:0] tbl [N_REGS];

  logic              last_idx;
  logic              phase_end;
  logic [DATA_W-1:0] addr_val;
  logic [DATA_W-1:0] data_val;

  assign last_idx  = (idx == IDX_W'(N_REGS - 1));
  assign phase_end = (cnt == CNT_W'(PHASE_CYC - 1));
  assign addr_val  = ADDR_BASE + DATA_W'(idx);
  assign data_val  = tbl[idx];
  assign RD        = 1'b1;
  assign cur_idx   = idx;

  // Register table: written only while idle so a burst sees a stable snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        tbl[i] <= '0;
      end
    end else if (ld_en && (state == IDLE) && (int'(ld_idx) < N_REGS)) begin
      tbl[ld_idx] <= ld_data;
    end else begin
      tbl <= tbl;
    end
  end

  // Burst sequencer; bus outputs are set on the edge that enters each phase, so
  // strobes and address/data never move on the same clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      mask     <= '0;
      AD       <= 1'b1;
      CS       <= 1'b1;
      WR       <= 1'b1;
      bus_data <= '0;
      bus_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mask  <= wr_mask;
            idx   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end else begin
            busy <= 1'b0;
          end
        end
        SCAN: begin
          if (mask[idx]) begin
            cnt      <= '0;
            AD       <= 1'b0;
            bus_data <= addr_val;
            bus_oe   <= 1'b1;
            state    <= ADDR_SU;
          end else if (last_idx) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ADDR_SU, DATA_SU: begin
          if (phase_end) begin
            cnt   <= '0;
            CS    <= 1'b0;
            WR    <= 1'b0;
            state <= (state == ADDR_SU) ? ADDR_ST : DATA_ST;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ADDR_ST, DATA_ST: begin
          if (phase_end) begin
            cnt   <= '0;
            CS    <= 1'b1;
            WR    <= 1'b1;
            state <= (state == ADDR_ST) ? ADDR_HD : DATA_HD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ADDR_HD, DATA_HD: begin
          if (phase_end) begin
            cnt    <= '0;
            bus_oe <= 1'b0;
            state  <= (state == ADDR_HD) ? ADDR_GAP : DATA_GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ADDR_GAP: begin
          if (phase_end) begin
            cnt      <= '0;
            AD       <= 1'b1;
            bus_data <= data_val;
            bus_oe   <= 1'b1;
            state    <= DATA_SU;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA_GAP: begin
          if (phase_end) begin
            cnt <= '0;
            if (last_idx) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= SCAN;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          AD    <= 1'b1;
          state <= IDLE;
        end
        default: begin
          AD     <= 1'b1;
          CS     <= 1'b1;
          WR     <= 1'b1;
          bus_oe <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_burst_writer.sv
// Bench for rtc_burst_writer: two instances (different base/phase) share stimulus and
// are checked every cycle against a trace-generating model, plus fixed expectations.
module tb_rtc_burst_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_en = 1'b0;
  logic       start = 1'b0;
  logic [2:0] ld_idx = 3'd0;
  logic [7:0] ld_data = 8'h00;
  logic [7:0] wr_mask = 8'h00;

  logic       ad0, cs0, wr0, rd0, oe0, busy0, done0;
  logic [7:0] bd0;
  logic [2:0] idx0;
  logic       ad1, cs1, wr1, rd1, oe1, busy1, done1;
  logic [7:0] bd1;
  logic [2:0] idx1;

  always #5 clk = ~clk;

  rtc_burst_writer #(.DATA_W(8), .N_REGS(8), .ADDR_BASE(8'h21), .PHASE_CYC(4)) dut0 (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .wr_mask(wr_mask), .start(start), .AD(ad0), .CS(cs0), .WR(wr0), .RD(rd0),
    .bus_data(bd0), .bus_oe(oe0), .cur_idx(idx0), .busy(busy0), .done(done0));

  rtc_burst_writer #(.DATA_W(8), .N_REGS(8), .ADDR_BASE(8'hFE), .PHASE_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .wr_mask(wr_mask), .start(start), .AD(ad1), .CS(cs1), .WR(wr1), .RD(rd1),
    .bus_data(bd1), .bus_oe(oe1), .cur_idx(idx1), .busy(busy1), .done(done1));

  typedef struct packed {
    logic       ad;
    logic       cs;
    logic       wr;
    logic       rd;
    logic [7:0] bd;
    logic       oe;
    logic [2:0] idx;
    logic       busy;
    logic       done;
  } exp_t;

  int n_chk = 0;
  int n_fail = 0;

  // model state per instance: expected outputs, pending trace, table copy
  exp_t       cur [2];
  exp_t       tr [2][512];
  int         tlen [2];
  int         tpos [2];
  logic [7:0] tbl [2][8];
  logic [7:0] base [2];
  int         pc [2];

  // burst observations
  logic [7:0] addr_l [2][16];
  logic [7:0] data_l [2][16];
  int na [2], nd [2], busy_c [2], cslow [2], done_c [2], done_k [2];
  logic prev_cs [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic exp_t rst_val();
    exp_t e;
    e.ad = 1'b1; e.cs = 1'b1; e.wr = 1'b1; e.rd = 1'b1; e.bd = 8'h00;
    e.oe = 1'b0; e.idx = 3'd0; e.busy = 1'b0; e.done = 1'b0;
    return e;
  endfunction

  function automatic exp_t obs(input int d);
    exp_t o;
    if (d == 0) begin
      o.ad = ad0; o.cs = cs0; o.wr = wr0; o.rd = rd0; o.bd = bd0;
      o.oe = oe0; o.idx = idx0; o.busy = busy0; o.done = done0;
    end else begin
      o.ad = ad1; o.cs = cs1; o.wr = wr1; o.rd = rd1; o.bd = bd1;
      o.oe = oe1; o.idx = idx1; o.busy = busy1; o.done = done1;
    end
    return o;
  endfunction

  // Expected cycle-by-cycle outputs of a whole burst, straight from the phase rules.
  task automatic build(input int d, input logic [7:0] m);
    exp_t e;
    logic [7:0] held, val;
    int n;
    n = 0;
    held = cur[d].bd;
    for (int i = 0; i < 8; i++) begin
      e = rst_val();
      e.bd = held; e.idx = 3'(i); e.busy = 1'b1;
      tr[d][n] = e; n++;
      if (m[i]) begin
        for (int ph = 0; ph < 2; ph++) begin
          val = (ph == 1) ? tbl[d][i] : 8'(base[d] + 8'(i));
          for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < pc[d]; c++) begin
              e.ad = (ph == 1);
              e.cs = (s != 1);
              e.wr = (s != 1);
              e.oe = (s != 3);
              e.bd = val;
              tr[d][n] = e; n++;
            end
          end
        end
        held = tbl[d][i];
      end
    end
    e = rst_val();
    e.bd = held; e.idx = 3'd7; e.busy = 1'b1; e.done = 1'b1;
    tr[d][n] = e; n++;
    tlen[d] = n;
    tpos[d] = 0;
  endtask

  // reference model advances on every clock edge or reset
  initial begin
    base[0] = 8'h21; base[1] = 8'hFE;
    pc[0] = 4;       pc[1] = 1;
    for (int d = 0; d < 2; d++) begin
      cur[d] = rst_val(); tlen[d] = 0; tpos[d] = 0;
      for (int i = 0; i < 8; i++) tbl[d][i] = 8'h00;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          cur[d] = rst_val(); tlen[d] = 0; tpos[d] = 0;
          for (int i = 0; i < 8; i++) tbl[d][i] = 8'h00;
        end else begin
          if (!cur[d].busy && ld_en) tbl[d][ld_idx] = ld_data;
          if (!cur[d].busy && start) build(d, wr_mask);
          if (tpos[d] < tlen[d]) begin
            cur[d] = tr[d][tpos[d]];
            tpos[d]++;
          end else begin
            cur[d].ad = 1'b1; cur[d].cs = 1'b1; cur[d].wr = 1'b1;
            cur[d].oe = 1'b0; cur[d].busy = 1'b0; cur[d].done = 1'b0;
          end
        end
      end
    end
  end

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("dut%0d outputs {ad,cs,wr,rd,bd,oe,idx,busy,done}", d),
            32'(obs(d)), 32'(cur[d]));
      end
    end
  end

  task automatic load(input logic [2:0] i, input logic [7:0] v);
    ld_en = 1'b1; ld_idx = i; ld_data = v;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run_burst(input logic [7:0] m, input bit poke);
    int k;
    exp_t o;
    logic [1:0] fin;
    for (int d = 0; d < 2; d++) begin
      na[d] = 0; nd[d] = 0; busy_c[d] = 0; cslow[d] = 0;
      done_c[d] = 0; done_k[d] = 0; prev_cs[d] = 1'b1;
    end
    wr_mask = m; start = 1'b1; k = 0; fin = 2'b00;
    while (fin != 2'b11 && k < 2000) begin
      @(negedge clk);
      k++;
      if (k == 1 || k == 4) begin start = 1'b0; ld_en = 1'b0; end
      if (poke && k == 3) begin
        start = 1'b1; ld_en = 1'b1; ld_idx = 3'd3; ld_data = 8'hEE;
      end
      for (int d = 0; d < 2; d++) begin
        o = obs(d);
        if (o.done) done_c[d]++;
        if (!fin[d]) begin
          if (o.busy) busy_c[d]++;
          if (!o.cs) cslow[d]++;
          if (!o.cs && prev_cs[d]) begin
            if (!o.ad && na[d] < 16) begin addr_l[d][na[d]] = o.bd; na[d]++; end
            if (o.ad && nd[d] < 16) begin data_l[d][nd[d]] = o.bd; nd[d]++; end
          end
          if (o.done) begin fin[d] = 1'b1; done_k[d] = k; end
        end
        prev_cs[d] = o.cs;
      end
    end
    chk("burst finished within cycle budget", 32'(k >= 2000), 32'd0);
    start = 1'b0; ld_en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (obs(d).done) done_c[d]++;
    end
  endtask

  initial begin
    logic [7:0] m;
    int k;
    @(negedge clk);
    chk("reset state dut0", 32'(obs(0)), 32'(rst_val()));
    rst = 1'b0;
    @(negedge clk);

    // single entry, full phase timing
    load(3'd0, 8'h59);
    run_burst(8'h01, 1'b0);
    chk("done cycle dut0 mask 01", 32'(done_k[0]), 32'd41);
    chk("done cycle dut1 mask 01", 32'(done_k[1]), 32'd17);
    chk("CS low cycles dut0 mask 01", 32'(cslow[0]), 32'd8);
    chk("address dut0 mask 01", {24'h0, addr_l[0][0]}, 32'h21);
    chk("data dut0 mask 01", {24'h0, data_l[0][0]}, 32'h59);
    chk("address dut1 mask 01", {24'h0, addr_l[1][0]}, 32'hFE);

    // sparse mask, ordered transactions
    for (int i = 0; i < 8; i++) load(3'(i), 8'h10 + 8'(i));
    run_burst(8'hA5, 1'b0);
    chk("transaction count mask A5", 32'(na[0]), 32'd4);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ea [4];
      logic [7:0] ed [4];
      ea[0] = 8'h21; ea[1] = 8'h23; ea[2] = 8'h26; ea[3] = 8'h28;
      ed[0] = 8'h10; ed[1] = 8'h12; ed[2] = 8'h15; ed[3] = 8'h17;
      chk($sformatf("A5 address %0d", i), {24'h0, addr_l[0][i]}, {24'h0, ea[i]});
      chk($sformatf("A5 data %0d", i), {24'h0, data_l[0][i]}, {24'h0, ed[i]});
    end

    // empty mask
    run_burst(8'h00, 1'b0);
    chk("busy cycles mask 00", 32'(busy_c[0]), 32'd9);
    chk("done cycle mask 00", 32'(done_k[0]), 32'd9);
    chk("CS low cycles mask 00", 32'(cslow[0] + cslow[1]), 32'd0);

    // address wrap on the FE-based instance
    run_burst(8'h07, 1'b0);
    chk("wrap address 0", {24'h0, addr_l[1][0]}, 32'hFE);
    chk("wrap address 1", {24'h0, addr_l[1][1]}, 32'hFF);
    chk("wrap address 2", {24'h0, addr_l[1][2]}, 32'h00);

    // start and load while busy are ignored
    run_burst(8'h01, 1'b1);
    chk("single done pulse dut0", 32'(done_c[0]), 32'd1);
    chk("single done pulse dut1", 32'(done_c[1]), 32'd1);
    run_burst(8'h08, 1'b0);
    chk("entry 3 unchanged", {24'h0, data_l[0][0]}, 32'h13);

    // asynchronous reset in the middle of an address strobe
    wr_mask = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0; k = 0;
    while (cs0 !== 1'b0 && k < 100) begin @(negedge clk); k++; end
    chk("strobe reached before reset", {31'h0, cs0}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async reset CS/WR/bus_oe/busy", {28'h0, cs0, wr0, oe0, busy0}, 32'b1100);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_burst(8'hFF, 1'b0);
    chk("data strobes after reset", 32'(nd[0]), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("table cleared entry %0d", i), {24'h0, data_l[0][i]}, 32'h00);

    // randomized loads and masks
    for (int it = 0; it < 20; it++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++)
        load(3'($urandom_range(0, 7)), 8'($urandom));
      m = 8'($urandom);
      run_burst(m, 1'($urandom_range(0, 1)));
      chk($sformatf("random burst %0d done cycle", it), 32'(done_k[0]),
          32'(8 + 32 * $countones(m) + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
